uart_cmd_frame: RTL

UART_CMD_FRAME -- requirements
Module: uart_cmd_frame

---
 rtl/uart_cmd_pkg.sv | 18 +
 rtl/uart_cmd_frame_timer.sv | 29 ++
 rtl/uart_cmd_frame.sv | 119 +++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared types and constants for the UART command framer
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_HOLD      = 2'd2
  } state_e;

  localparam logic [7:0]  CMD_NOP            = 8'h00;
  localparam logic [7:0]  OVERRUN_MAX        = 8'hFF;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1000000;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == OVERRUN_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_frame_timer.sv
// rtl/uart_cmd_frame_timer.sv - inter-byte timeout counter (module frame_timer)
module frame_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [23:0] LAST = 24'(TIMEOUT_CYCLES - 1);

  logic [23:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = cnt_q + 24'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_frame.sv
// rtl/uart_cmd_frame.sv - pairs received UART bytes into command/data frames
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module uart_cmd_frame
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rec,
  input  logic [7:0] uart_data_out,
  input  logic       command_done,
  output logic       cmd_valid,
  output logic [7:0] command,
  output logic [7:0] data,
  output logic       frame_timeout,
  output logic [7:0] overrun_cnt
);

  state_e     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic [7:0] command_q, command_d;
  logic [7:0] data_q, data_d;
  logic [7:0] overrun_q, overrun_d;
  logic       fto_d;
  logic       timer_expired;

`ifdef CMD_TIMEOUT_EN
  logic fto_q;

  frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .clear   (state_q != ST_WAIT_DATA),
    .enable  ((state_q == ST_WAIT_DATA) && !uart_rec),
    .expired (timer_expired)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) fto_q <= 1'b0;
    else            fto_q <= fto_d;
  end

  assign frame_timeout = fto_q;
`else
  assign timer_expired = 1'b0;
  assign frame_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    cmd_valid_d = cmd_valid_q;
    command_d   = command_q;
    data_d      = data_q;
    overrun_d   = overrun_q;
    fto_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (uart_rec && uart_data_out != CMD_NOP) begin
          pend_d  = uart_data_out;
          state_d = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        // A byte on the expiry cycle still completes the frame.
        if (uart_rec) begin
          command_d   = pend_q;
          data_d      = uart_data_out;
          cmd_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else if (timer_expired) begin
          pend_d  = CMD_NOP;
          fto_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (command_done) begin
          cmd_valid_d = 1'b0;
          command_d   = CMD_NOP;
          state_d     = ST_IDLE;
          if (uart_rec && uart_data_out != CMD_NOP) begin
            pend_d  = uart_data_out;
            state_d = ST_WAIT_DATA;
          end
        end else if (uart_rec) begin
          overrun_d = sat_inc8(overrun_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      pend_q      <= CMD_NOP;
      cmd_valid_q <= 1'b0;
      command_q   <= CMD_NOP;
      data_q      <= 8'h00;
      overrun_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      cmd_valid_q <= cmd_valid_d;
      command_q   <= command_d;
      data_q      <= data_d;
      overrun_q   <= overrun_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign command     = command_q;
  assign data        = data_q;
  assign overrun_cnt = overrun_q;

endmodule
